hub75_frame_scan: RTL and testbench
===================================

Name: hub75_frame_scan

Overview:
- Display-side reader for the two 64x64 split frame-buffer memories written by the cursor/paint logic.
  - Memory 0 holds the upper half, rows 0..31.
  - Memory 1 holds the lower half, rows 32..63, with row offset subtracted.
- Scans both memories in parallel, one row pair at a time.
- Drives a HUB75-style LED panel: two RGB bit lanes, shift clock, latch, active-low output enable and row select.
- Colour depth comes from binary-coded modulation over 4-bit-per-channel 12'hRGB pixels.

Parameters:
- IMG_WIDTH, 64: pixels per row; columns 0..IMG_WIDTH-1.
- HALF_ROWS, 32: rows per memory; row_sel range 0..HALF_ROWS-1.
- COLOR_BITS, 4: bit-planes per channel.
- BASE_TIME, 16: display cycles for plane 0; plane p displays BASE_TIME<<p cycles.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- rd_addr, output, 12: read address into both memories, row*IMG_WIDTH+col, zero-extended.
- rd_data0, input, 12: memory 0 read data; synchronous, valid 1 cycle after rd_addr.
- rd_data1, input, 12: memory 1 read data; same timing as rd_data0.
- r0 / g0 / b0, output, 1 each: upper-half colour bits.
- r1 / g1 / b1, output, 1 each: lower-half colour bits.
- sclk, output, 1: panel shift clock; panel samples on rising edge.
- latch, output, 1: panel latch pulse.
- oe_n, output, 1: panel output enable, active low.
- row_sel, output, 5: panel row address.
- frame_start, output, 1: one-cycle pulse when row 0 / plane 0 scanning begins.

Behaviour:
- Clock and reset: clock clk. Reset is named reset; it is synchronous and active-high.
- Reset values:
  - rd_addr=0, all colour bits=0, sclk=0, latch=0, oe_n=1, row_sel=0, frame_start=0.
  - Internal col=0, row=0, plane=0, state=FETCH.
- Pixel format: R=[11:8], G=[7:4], B=[3:0].
  - For plane p: r0=rd_data0[8+p], g0=rd_data0[4+p], b0=rd_data0[p]; r1/g1/b1 taken likewise from rd_data1.
- FSM states: FETCH, LOAD, CLOCK, LATCH, DISPLAY.
- FETCH (1 cycle):
  - Drive rd_addr=row*IMG_WIDTH+col; sclk=0; oe_n=1.
  - Go to LOAD.
- LOAD (1 cycle):
  - Read data is valid; register the six plane bits onto the colour outputs; sclk stays 0.
  - Go to CLOCK.
- CLOCK (1 cycle):
  - sclk=1; colour outputs held stable.
  - If col==IMG_WIDTH-1: col<=0, go to LATCH.
  - Else: col++, go to FETCH.
- Shift phase cost: exactly 3*IMG_WIDTH cycles per plane (192 at default).
- LATCH (1 cycle):
  - latch=1, row_sel<=row, oe_n=1, sclk=0.
  - Load the display counter with BASE_TIME<<plane; go to DISPLAY.
- DISPLAY:
  - oe_n=0 for exactly BASE_TIME<<plane cycles.
  - Then oe_n=1 and advance:
    - plane++.
    - On plane wrap (COLOR_BITS-1 → 0): row++.
    - On row wrap (HALF_ROWS-1 → 0): frame wraps.
  - Go to FETCH.
- oe_n is low only in DISPLAY. No shifting overlaps display, so there is no ghosting.
- frame_start is asserted in the FETCH cycle of col 0, row 0, plane 0. This includes the first FETCH after reset.
- Counter widths:
  - The display counter must hold BASE_TIME<<(COLOR_BITS-1); 8 bits at default, generally sized by clog2.
  - Address arithmetic is done at 12 bits. row*IMG_WIDTH+col must not exceed 4095; this is a parameter constraint.
- Memories are dual-port. Concurrent writes from the paint logic are allowed. A pixel read mid-update may show old or new data; no tearing protection.
- Reset mid-operation (any state): next cycle all outputs return to their reset values (oe_n=1), and scanning restarts at row 0, plane 0, col 0.
- Row period:
  - COLOR_BITS*(3*IMG_WIDTH+1) + BASE_TIME*(2^COLOR_BITS−1) cycles.
- Frame period: HALF_ROWS × row period.

Decomposition:
- Shared package holds:
  - Pixel field offsets (R_LSB=8, G_LSB=4, B_LSB=0).
  - The 12-bit pixel/address widths.
  - The FSM state encoding.
  - The default panel geometry (64 wide, 32 half rows), so the paint logic and this reader agree on the memory split.
- One sub-module, hub75_bcm_timer:
  - Loadable down-counter with done flag.
  - Inputs: load, plane.
  - Output: active; oe_n is derived from it.

Test Plan:
- Reset:
  - Hold reset 3 cycles → oe_n=1, sclk=0, latch=0, rd_addr=0.
  - After release → frame_start=1 in the first cycle; rd_addr sequence 0,1,2,… every 3 cycles; sclk rising every 3rd cycle.
- Pixel mapping:
  - mem0[0]=12'hF00, mem1[0]=12'h00F, all others 0 → plane 0, first sclk rise: r0=1, b1=1, the other four bits 0.
  - All later columns of that row: all six bits 0.
- BCM timing:
  - BASE_TIME=2 → oe_n low exactly 2, 4, 8, 16 cycles for planes 0..3 of each row.
  - Exactly one latch pulse precedes each display window, with oe_n=1 during that latch cycle.
- Addressing:
  - During row 5, col 10 → rd_addr=330.
  - row_sel=5 at the latch for that row.
- Frame wrap:
  - BASE_TIME=2 → frame_start pulses exactly every 32*(4*193+30)=25664 cycles.
  - row_sel returns 31→0 at that point.
- Reset mid-DISPLAY:
  - Assert reset while oe_n=0 in row 7 → next cycle oe_n=1.
  - After release, scanning restarts with rd_addr=0, frame_start=1, row_sel=0 at the first latch.

Source files
------------

// File: rtl/hub75_frame_scan_pkg.sv
// hub75_frame_scan_pkg
// Shared definitions for the split 64x64 frame buffer: pixel field offsets,
// pixel/address widths, default panel geometry (so the paint logic and the
// display reader agree on the upper/lower memory split) and the scan FSM
// state encoding.
package hub75_frame_scan_pkg;

  localparam int unsigned PIX_W         = 12;  // 12'hRGB, 4 bits per channel
  localparam int unsigned ADDR_W        = 12;  // row*IMG_WIDTH+col
  localparam int unsigned ROW_SEL_W     = 5;   // panel row address width

  localparam int unsigned R_LSB         = 8;
  localparam int unsigned G_LSB         = 4;
  localparam int unsigned B_LSB         = 0;

  localparam int unsigned DEF_IMG_WIDTH = 64;
  localparam int unsigned DEF_HALF_ROWS = 32;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CLOCK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } scan_state_t;

  // Extract the {R,G,B} bits of one bit-plane from a 12'hRGB pixel.
  function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix,
                                            input int unsigned        plane);
    logic [PIX_W-1:0] sh;
    sh = pix >> plane;
    return {sh[R_LSB], sh[G_LSB], sh[B_LSB]};
  endfunction

endpackage

// File: rtl/hub75_frame_scan_if.sv
// hub75_frame_scan_if
// Bundles the frame-buffer read port and the HUB75 panel signals.
//   rd_addr            : read address into both half-frame memories
//   rd_data0/rd_data1  : upper/lower memory read data (1-cycle latency)
//   r0 g0 b0 / r1 g1 b1: upper/lower half colour lanes
//   sclk, latch, oe_n  : shift clock, latch pulse, active-low output enable
//   row_sel            : panel row address
//   frame_start        : pulse when row 0 / plane 0 scanning begins
// master = scanner side, slave = memory/panel side.
interface hub75_frame_scan_if;
  import hub75_frame_scan_pkg::*;

  logic [ADDR_W-1:0]    rd_addr;
  logic [PIX_W-1:0]     rd_data0;
  logic [PIX_W-1:0]     rd_data1;
  logic                 r0, g0, b0;
  logic                 r1, g1, b1;
  logic                 sclk;
  logic                 latch;
  logic                 oe_n;
  logic [ROW_SEL_W-1:0] row_sel;
  logic                 frame_start;

  modport master (
    output rd_addr,
    input  rd_data0, rd_data1,
    output r0, g0, b0, r1, g1, b1,
    output sclk, latch, oe_n, row_sel, frame_start
  );

  modport slave (
    input  rd_addr,
    output rd_data0, rd_data1,
    input  r0, g0, b0, r1, g1, b1,
    input  sclk, latch, oe_n, row_sel, frame_start
  );

endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer
// Binary-coded-modulation display timer. A load pulse starts a window of
// BASE_TIME<<plane cycles; active is high for exactly that many cycles
// following the load, done flags the last active cycle.
//   clk, reset : clock, synchronous active-high reset
//   load       : start a new display window
//   plane      : bit-plane selecting the window length
//   active     : display window in progress (panel oe_n = ~active)
//   done       : final cycle of the window
module hub75_bcm_timer #(
  parameter int unsigned BASE_TIME  = 16,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned PLANE_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PLANE_W-1:0] plane,
  output logic               active,
  output logic               done
);

  localparam int unsigned MAX_TIME = BASE_TIME << (COLOR_BITS - 1);
  localparam int unsigned CNT_W    = $clog2(MAX_TIME + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(BASE_TIME) << plane;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign active = (cnt != '0);
  assign done   = (cnt == CNT_W'(1));

endmodule

// File: rtl/hub75_frame_scan.sv
// hub75_frame_scan
// Display-side reader for the split frame buffer. Both half memories are
// scanned in parallel one row pair at a time; each row is shifted out once
// per bit-plane and shown for BASE_TIME<<plane cycles (binary-coded
// modulation). Shifting and display never overlap.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hub75_frame_scan_if.master (memory read port + panel pins)
module hub75_frame_scan
  import hub75_frame_scan_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned HALF_ROWS  = DEF_HALF_ROWS,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned BASE_TIME  = 16
) (
  input  logic               clk,
  input  logic               reset,
  hub75_frame_scan_if.master bus
);

  localparam int unsigned COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W   = (HALF_ROWS  > 1) ? $clog2(HALF_ROWS)  : 1;
  localparam int unsigned PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(HALF_ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOR_BITS - 1);

  scan_state_t          state, state_n;
  logic [COL_W-1:0]     col, col_n;
  logic [ROW_W-1:0]     row, row_n;
  logic [PLANE_W-1:0]   plane, plane_n;
  logic                 timer_load;
  logic                 timer_active;
  logic                 timer_done;
  logic [5:0]           colour_q;   // {r0,g0,b0,r1,g1,b1}
  logic [ROW_SEL_W-1:0] row_sel_q;
  logic [ADDR_W-1:0]    addr_c;

  hub75_bcm_timer #(
    .BASE_TIME  (BASE_TIME),
    .COLOR_BITS (COLOR_BITS),
    .PLANE_W    (PLANE_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .plane  (plane),
    .active (timer_active),
    .done   (timer_done)
  );

  // State and scan position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      col   <= '0;
      row   <= '0;
      plane <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      plane <= plane_n;
    end
  end

  // Next-state and scan position advance.
  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    plane_n    = plane;
    timer_load = 1'b0;
    unique case (state)
      ST_FETCH:   state_n = ST_LOAD;
      ST_LOAD:    state_n = ST_CLOCK;
      ST_CLOCK: begin
        if (col == LAST_COL) begin
          col_n   = '0;
          state_n = ST_LATCH;
        end else begin
          col_n   = col + COL_W'(1);
          state_n = ST_FETCH;
        end
      end
      ST_LATCH: begin
        timer_load = 1'b1;
        state_n    = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (timer_done) begin
          state_n = ST_FETCH;
          if (plane == LAST_PLANE) begin
            plane_n = '0;
            row_n   = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
          end else begin
            plane_n = plane + PLANE_W'(1);
          end
        end
      end
      default:    state_n = ST_FETCH;
    endcase
  end

  // Colour lanes capture the current plane in LOAD (read data valid) and
  // stay put through the CLOCK cycle; row_sel only changes at the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      colour_q  <= '0;
      row_sel_q <= '0;
    end else begin
      if (state == ST_LOAD) begin
        colour_q <= {plane_bits(bus.rd_data0, int'(plane)),
                     plane_bits(bus.rd_data1, int'(plane))};
      end
      if (state == ST_LATCH) begin
        row_sel_q <= ROW_SEL_W'(row);
      end
    end
  end

  // The address is decoded straight from the position counters, so it is
  // already valid in FETCH and reads 0 whenever the counters are reset.
  always_comb begin
    addr_c = ADDR_W'(row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col);
  end

  assign bus.rd_addr     = addr_c;
  assign {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} = colour_q;
  assign bus.sclk        = (state == ST_CLOCK);
  assign bus.latch       = (state == ST_LATCH);
  assign bus.oe_n        = ~timer_active;
  assign bus.row_sel     = row_sel_q;
  // Decoded from state so it is already high in the first FETCH after reset.
  assign bus.frame_start = ~reset && (state == ST_FETCH) &&
                           (col == '0) && (row == '0) && (plane == '0);

endmodule

// File: tb/tb_hub75_frame_scan.sv
module tb_hub75_frame_scan;
  import hub75_frame_scan_pkg::*;

  localparam int W  = 64;
  localparam int HR = 32;
  localparam int CB = 4;
  localparam int BT = 2;
  localparam int RP = CB * (3 * W + 1) + BT * ((1 << CB) - 1);  // 802
  localparam int FP = HR * RP;                                   // 25664

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hub75_frame_scan_if bus();

  hub75_frame_scan #(
    .IMG_WIDTH  (W),
    .HALF_ROWS  (HR),
    .COLOR_BITS (CB),
    .BASE_TIME  (BT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [11:0] mem0 [4096];
  logic [11:0] mem1 [4096];

  always @(posedge clk) begin
    bus.rd_data0 <= mem0[bus.rd_addr];
    bus.rd_data1 <= mem1[bus.rd_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int model_t = 0;
  bit model_on = 1'b0;
  int abs_cyc = 0;

  always @(posedge clk) begin
    abs_cyc <= abs_cyc + 1;
    if (reset) begin
      model_t  <= 0;
      model_on <= 1'b1;
    end else begin
      model_t <= model_t + 1;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0d)", name, got, want, model_t);
    end
  endtask

  // Expected outputs from elapsed cycles since reset release.
  // Bits: [26]frame_start [25]sclk [24]latch [23]oe_n [22:11]rd_addr
  //       [10:6]row_sel [5:0]{r0,g0,b0,r1,g1,b1}
  function automatic void model(input int t, output logic [26:0] e,
                                output logic [26:0] m);
    int tf, row, tr, p, col, ph;
    logic [11:0] a, s0, s1;
    tf = t % FP;
    row = tf / RP;
    tr = tf % RP;
    p = 0;
    while (tr >= 3 * W + 1 + (BT << p)) begin
      tr -= 3 * W + 1 + (BT << p);
      p++;
    end
    e = '0;
    m = '0;
    m[26:23] = 4'hF;
    e[26] = (tf == 0);
    if (tr < 3 * W) begin
      col = tr / 3;
      ph = tr % 3;
      a = 12'(row * W + col);
      e[25] = (ph == 2);
      e[23] = 1'b1;
      if (ph == 0) begin
        e[22:11] = a;
        m[22:11] = '1;
      end
      if (ph == 2) begin
        s0 = mem0[a] >> p;
        s1 = mem1[a] >> p;
        e[5:0] = {s0[8], s0[4], s0[0], s1[8], s1[4], s1[0]};
        m[5:0] = '1;
      end
    end else if (tr == 3 * W) begin
      e[24] = 1'b1;
      e[23] = 1'b1;
    end else begin
      e[23] = 1'b0;
      e[10:6] = 5'(row);
      m[10:6] = '1;
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [26:0] e, m, act;
    if (model_on && !reset) begin
      model(model_t, e, m);
      act = {bus.frame_start, bus.sclk, bus.latch, bus.oe_n, bus.rd_addr,
             bus.row_sel, bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1};
      n_cmp++;
      if (((act ^ e) & m) !== 27'd0) begin
        n_bad++;
        $display("FAIL cycle t=%0d: got %h want %h mask %h", model_t, act, e, m);
      end
    end
  end

  // Display window lengths and the single latch preceding each window.
  int  lo_len = 0, win_idx = 0, latch_cnt = 0;
  bit  prev_oe = 1'b1, prev_latch = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      lo_len = 0; win_idx = 0; latch_cnt = 0;
      prev_oe = 1'b1; prev_latch = 1'b0;
    end else begin
      if (bus.latch === 1'b1) latch_cnt++;
      if (bus.oe_n === 1'b0) begin
        if (prev_oe) begin
          n_cmp++;
          if (!(prev_latch && latch_cnt == 1)) begin
            n_bad++;
            $display("FAIL latch_before_window %0d: got latch_prev=%0d count=%0d want 1/1",
                     win_idx, prev_latch, latch_cnt);
          end
        end
        lo_len++;
      end else if (!prev_oe) begin
        n_cmp++;
        if (lo_len != (BT << (win_idx % CB))) begin
          n_bad++;
          $display("FAIL window_len %0d: got %0d want %0d", win_idx, lo_len,
                   BT << (win_idx % CB));
        end
        win_idx++;
        lo_len = 0;
        latch_cnt = 0;
      end
      prev_oe = (bus.oe_n !== 1'b0);
      prev_latch = (bus.latch === 1'b1);
    end
  end

  // frame_start spacing.
  int last_fs = -1;
  always @(negedge clk) begin
    if (reset) begin
      last_fs = -1;
    end else if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        n_cmp++;
        if (abs_cyc - last_fs != FP) begin
          n_bad++;
          $display("FAIL frame_period: got %0d want %0d", abs_cyc - last_fs, FP);
        end
      end
      last_fs = abs_cyc;
    end
  end

  task automatic wait_t(input int target);
    int b;
    b = 0;
    while (model_t != target && b < 40000 && n_bad < 50) begin
      @(negedge clk);
      b++;
    end
    if (model_t != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_t: got t=%0d want t=%0d", model_t, target);
    end
  endtask

  function automatic int colours();
    return int'({bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1});
  endfunction

  initial begin
    #(10 * 90000);
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = (a < W) ? 12'h000 : 12'(a * 37 + 5);
      mem1[a] = (a < W) ? 12'h000 : 12'(a * 91 + 165);
    end
    mem0[0] = 12'hF00;
    mem1[0] = 12'h00F;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe_n", bus.oe_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_latch", bus.latch, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_row_sel", bus.row_sel, 0);
    reset = 1'b0;
    #1;
    wait_t(0);
    chk("first_frame_start", bus.frame_start, 1);
    chk("first_rd_addr", bus.rd_addr, 0);
    wait_t(2);
    chk("col0_sclk", bus.sclk, 1);
    chk("col0_colours", colours(), 6'b100001);
    wait_t(3);
    chk("col1_rd_addr", bus.rd_addr, 1);
    chk("col1_fetch_sclk", bus.sclk, 0);
    wait_t(5);
    chk("col1_sclk", bus.sclk, 1);
    chk("col1_colours", colours(), 0);
    wait_t(6);
    chk("col2_rd_addr", bus.rd_addr, 2);
    wait_t(192);
    chk("row0_latch", bus.latch, 1);
    chk("row0_latch_oe_n", bus.oe_n, 1);
    wait_t(193);
    chk("row0_display_oe_n", bus.oe_n, 0);
    chk("row0_row_sel", bus.row_sel, 0);
    wait_t(4040);
    chk("row5_col10_addr", bus.rd_addr, 330);
    wait_t(4202);
    chk("row5_latch", bus.latch, 1);
    wait_t(4203);
    chk("row5_row_sel", bus.row_sel, 5);
    wait_t(25663);
    chk("row31_row_sel", bus.row_sel, 31);
    chk("row31_oe_n", bus.oe_n, 0);
    wait_t(25664);
    chk("wrap_frame_start", bus.frame_start, 1);
    chk("wrap_rd_addr", bus.rd_addr, 0);
    wait_t(25857);
    chk("wrap_row_sel", bus.row_sel, 0);
    wait_t(31471);
    chk("row7_oe_n", bus.oe_n, 0);
    chk("row7_row_sel", bus.row_sel, 7);

    @(posedge clk);
    #1;
    chk("pre_reset_oe_n", bus.oe_n, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_oe_n", bus.oe_n, 1);
    chk("midrst_sclk", bus.sclk, 0);
    chk("midrst_latch", bus.latch, 0);
    chk("midrst_rd_addr", bus.rd_addr, 0);
    chk("midrst_row_sel", bus.row_sel, 0);
    chk("midrst_colours", colours(), 0);
    chk("midrst_frame_start", bus.frame_start, 0);
    reset = 1'b0;
    #1;
    chk("restart_frame_start", bus.frame_start, 1);
    chk("restart_rd_addr", bus.rd_addr, 0);
    wait_t(192);
    chk("restart_latch", bus.latch, 1);
    wait_t(193);
    chk("restart_row_sel", bus.row_sel, 0);
    chk("restart_oe_n", bus.oe_n, 0);
    wait_t(2 * RP + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
